// File: rtl/core_ctrl_pkg.sv
// Shared types and defaults for the NPC core sequencer.
package core_ctrl_pkg;

    // Sequencer states; the encoding is visible on the debug state port.
    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_IWAIT = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MREQ  = 3'd3,
        ST_MRESP = 3'd4,
        ST_WB    = 3'd5,
        ST_HALT  = 3'd6
    } state_t;

    // Reason the core stopped.
    localparam logic [1:0] HALT_NONE    = 2'd0;
    localparam logic [1:0] HALT_EBREAK  = 2'd1;
    localparam logic [1:0] HALT_ILLEGAL = 2'd2;
    localparam logic [1:0] HALT_TIMEOUT = 2'd3;

    localparam logic [63:0] DEF_RESET_PC = 64'h0000_0000_8000_0000;
    localparam int unsigned DEF_TIMEOUT  = 1024;
    localparam int unsigned DEF_TW       = 11;

endpackage

// File: rtl/core_seq_ctrl_hs_timeout_cnt.sv
// Handshake wait counter: counts stalled cycles and flags when the limit is reached.
module hs_timeout_cnt
    import core_ctrl_pkg::*;
#(
    parameter int unsigned TW = DEF_TW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clear,
    input  logic          i_enable,
    input  logic [TW-1:0] i_limit,
    output logic          o_expired
);

    logic [TW-1:0] r_count;

    // Clear wins over count so a state change always starts a fresh wait window.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + TW'(1);
        end
    end

    assign o_expired = (r_count == i_limit);

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle sequencer: owns PC/IR, drives memory handshakes, gates writeback, halts the core.
module core_seq_ctrl
    import core_ctrl_pkg::*;
#(
    parameter logic [63:0] RESET_PC = DEF_RESET_PC,
    parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
    parameter int unsigned TW       = DEF_TW
) (
    input  logic        clock,
    input  logic        reset,
    output logic        io_imem_req_valid,
    input  logic        io_imem_req_ready,
    output logic [63:0] io_imem_req_addr,
    input  logic        io_imem_resp_valid,
    input  logic [31:0] io_imem_resp_data,
    output logic [31:0] io_inst,
    output logic [63:0] io_pc,
    input  logic        io_dec_reg_write,
    input  logic        io_dec_mem_read,
    input  logic        io_dec_mem_write,
    input  logic        io_dec_ebreak,
    input  logic        io_dec_illegal,
    input  logic [63:0] io_next_pc,
    output logic        io_dmem_req_valid,
    input  logic        io_dmem_req_ready,
    input  logic        io_dmem_resp_valid,
    output logic        io_rf_wen,
    output logic        io_halt,
    output logic [1:0]  io_halt_code,
    output logic [2:0]  io_state,
    output logic [63:0] io_cycle_cnt,
    output logic [63:0] io_instret
);

    state_t      r_state;
    logic [63:0] r_pc;
    logic [31:0] r_inst;
    logic [63:0] r_cycle_cnt;
    logic [63:0] r_instret;
    logic [1:0]  r_halt_code;

    state_t      w_next_state;
    logic [1:0]  w_next_code;
    logic        w_waiting;
    logic        w_exit;
    logic        w_retire;
    logic        w_expired;
    logic        w_state_chg;

    // Next-state logic; a waiting state that meets its exit in the limit cycle still moves on.
    always_comb begin
        w_next_state = r_state;
        w_next_code  = r_halt_code;
        w_waiting    = 1'b0;
        w_exit       = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_waiting = 1'b1;
                w_exit    = io_imem_req_ready;
                if (w_exit) w_next_state = ST_IWAIT;
            end
            ST_IWAIT: begin
                w_waiting = 1'b1;
                w_exit    = io_imem_resp_valid;
                if (w_exit) w_next_state = ST_EXEC;
            end
            ST_EXEC: begin
                if (io_dec_illegal) begin
                    w_next_state = ST_HALT;
                    w_next_code  = HALT_ILLEGAL;
                end else if (io_dec_ebreak) begin
                    w_next_state = ST_HALT;
                    w_next_code  = HALT_EBREAK;
                    w_retire     = 1'b1;
                end else if (io_dec_mem_read || io_dec_mem_write) begin
                    w_next_state = ST_MREQ;
                end else begin
                    w_next_state = ST_WB;
                end
            end
            ST_MREQ: begin
                w_waiting = 1'b1;
                w_exit    = io_dmem_req_ready;
                if (w_exit) w_next_state = ST_MRESP;
            end
            ST_MRESP: begin
                w_waiting = 1'b1;
                w_exit    = io_dmem_resp_valid;
                if (w_exit) w_next_state = ST_WB;
            end
            ST_WB: begin
                w_retire     = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_HALT: w_next_state = ST_HALT;
            default: w_next_state = ST_FETCH;
        endcase
        if (w_waiting && !w_exit && w_expired) begin
            w_next_state = ST_HALT;
            w_next_code  = HALT_TIMEOUT;
        end
    end

    assign w_state_chg = (w_next_state != r_state);

    hs_timeout_cnt #(
        .TW(TW)
    ) u_timer (
        .i_clk     (clock),
        .i_rst_n   (reset),
        .i_clear   (w_state_chg),
        .i_enable  (w_waiting && !w_exit),
        .i_limit   (TW'(TIMEOUT - 1)),
        .o_expired (w_expired)
    );

    // State, halt reason and performance counters; counting stops once halted.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= ST_FETCH;
            r_halt_code <= HALT_NONE;
            r_cycle_cnt <= '0;
            r_instret   <= '0;
        end else begin
            r_state     <= w_next_state;
            r_halt_code <= w_next_code;
            if (r_state != ST_HALT) r_cycle_cnt <= r_cycle_cnt + 64'd1;
            if (w_retire)           r_instret   <= r_instret + 64'd1;
        end
    end

    // PC advances only at writeback; IR is captured only on the IWAIT response.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pc   <= RESET_PC;
            r_inst <= '0;
        end else begin
            if (r_state == ST_IWAIT && io_imem_resp_valid) r_inst <= io_imem_resp_data;
            if (r_state == ST_WB)                          r_pc   <= io_next_pc;
        end
    end

    assign io_imem_req_valid = (r_state == ST_FETCH);
    assign io_imem_req_addr  = r_pc;
    assign io_inst           = r_inst;
    assign io_pc             = r_pc;
    assign io_dmem_req_valid = (r_state == ST_MREQ);
    assign io_rf_wen         = (r_state == ST_WB) && io_dec_reg_write;
    assign io_halt           = (r_state == ST_HALT);
    assign io_halt_code      = r_halt_code;
    assign io_state          = r_state;
    assign io_cycle_cnt      = r_cycle_cnt;
    assign io_instret        = r_instret;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Scoreboard bench for core_seq_ctrl with a reactive memory/decoder model.
module tb_core_seq_ctrl;

    localparam int          TIMEOUT = 1024;
    localparam logic [63:0] RPC     = 64'h0000_0000_8000_0000;

    localparam logic [31:0] I_ADDI  = 32'h00500093;
    localparam logic [31:0] I_SD    = 32'h0010B023;
    localparam logic [31:0] I_LD    = 32'h0000B083;
    localparam logic [31:0] I_EBRK  = 32'h00100073;
    localparam logic [31:0] I_ILL   = 32'hFFFFFFFF;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        io_imem_req_valid;
    logic        io_imem_req_ready = 1'b0;
    logic [63:0] io_imem_req_addr;
    logic        io_imem_resp_valid = 1'b0;
    logic [31:0] io_imem_resp_data = '0;
    logic [31:0] io_inst;
    logic [63:0] io_pc;
    logic        io_dec_reg_write = 1'b0;
    logic        io_dec_mem_read = 1'b0;
    logic        io_dec_mem_write = 1'b0;
    logic        io_dec_ebreak = 1'b0;
    logic        io_dec_illegal = 1'b0;
    logic [63:0] io_next_pc = '0;
    logic        io_dmem_req_valid;
    logic        io_dmem_req_ready = 1'b0;
    logic        io_dmem_resp_valid = 1'b0;
    logic        io_rf_wen;
    logic        io_halt;
    logic [1:0]  io_halt_code;
    logic [2:0]  io_state;
    logic [63:0] io_cycle_cnt;
    logic [63:0] io_instret;

    core_seq_ctrl dut (
        .clock              (clock),
        .reset              (reset),
        .io_imem_req_valid  (io_imem_req_valid),
        .io_imem_req_ready  (io_imem_req_ready),
        .io_imem_req_addr   (io_imem_req_addr),
        .io_imem_resp_valid (io_imem_resp_valid),
        .io_imem_resp_data  (io_imem_resp_data),
        .io_inst            (io_inst),
        .io_pc              (io_pc),
        .io_dec_reg_write   (io_dec_reg_write),
        .io_dec_mem_read    (io_dec_mem_read),
        .io_dec_mem_write   (io_dec_mem_write),
        .io_dec_ebreak      (io_dec_ebreak),
        .io_dec_illegal     (io_dec_illegal),
        .io_next_pc         (io_next_pc),
        .io_dmem_req_valid  (io_dmem_req_valid),
        .io_dmem_req_ready  (io_dmem_req_ready),
        .io_dmem_resp_valid (io_dmem_resp_valid),
        .io_rf_wen          (io_rf_wen),
        .io_halt            (io_halt),
        .io_halt_code       (io_halt_code),
        .io_state           (io_state),
        .io_cycle_cnt       (io_cycle_cnt),
        .io_instret         (io_instret)
    );

    always #5 clock = ~clock;

    // Expected per-cycle view: state, rf_wen, imem_req_valid, dmem_req_valid.
    typedef struct packed {
        logic [2:0] st;
        logic       rf;
        logic       iv;
        logic       dv;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] imem_word = I_ADDI;
    int          imem_delay = 0;
    int          dmem_delay = 0;
    bit          dmem_resp_en = 1'b1;
    bit          stale_en = 1'b0;
    logic [2:0]  prev_st = 3'd7;
    int          cnt = 0;

    // Expected value for one cycle; valids follow the state by definition.
    task automatic push(input logic [2:0] st, input logic rf);
        exp_t x;
        x.st = st;
        x.rf = rf;
        x.iv = (st == 3'd0);
        x.dv = (st == 3'd3);
        sb.push_back(x);
    endtask

    task automatic track();
        if (io_state == prev_st) cnt++;
        else cnt = 0;
        prev_st = io_state;
    endtask

    // Memory and decoder model reacting to the current DUT state.
    task automatic drive();
        io_imem_req_ready  = (io_state == 3'd0) && (cnt >= imem_delay);
        io_imem_resp_valid = (io_state == 3'd1) || stale_en;
        io_imem_resp_data  = (io_state == 3'd1) ? imem_word : 32'hDEAD_BEEF;
        io_dmem_req_ready  = (io_state == 3'd3) && (cnt >= dmem_delay);
        io_dmem_resp_valid = ((io_state == 3'd4) && dmem_resp_en) || stale_en;
        io_dec_reg_write   = (io_inst == I_ADDI) || (io_inst == I_LD) || (io_inst == I_ILL);
        io_dec_mem_read    = (io_inst == I_LD);
        io_dec_mem_write   = (io_inst == I_SD);
        io_dec_ebreak      = (io_inst == I_EBRK);
        io_dec_illegal     = (io_inst == I_ILL);
        io_next_pc         = io_pc + 64'd4;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        track();
        drive();
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        prev_st = 3'd7;
        track();
        drive();
    endtask

    task automatic test_reset();
        imem_word = I_ADDI; imem_delay = 0; dmem_delay = 0; dmem_resp_en = 1'b1; stale_en = 1'b0;
        apply_reset();
        checks++;
        if ({io_state, io_imem_req_valid, io_dmem_req_valid, io_rf_wen, io_halt} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_ctrl: st=%0d iv=%b dv=%b rf=%b halt=%b, want st=0 iv=1 dv=0 rf=0 halt=0",
                     io_state, io_imem_req_valid, io_dmem_req_valid, io_rf_wen, io_halt);
        end
        checks++;
        if (io_pc !== RPC || io_imem_req_addr !== RPC) begin
            errors++;
            $display("FAIL reset_pc: pc=%h addr=%h want %h", io_pc, io_imem_req_addr, RPC);
        end
        checks++;
        if (io_inst !== 32'd0 || io_halt_code !== 2'd0) begin
            errors++;
            $display("FAIL reset_inst_code: inst=%h code=%0d want 0/0", io_inst, io_halt_code);
        end
        checks++;
        if (io_cycle_cnt !== 64'd0 || io_instret !== 64'd0) begin
            errors++;
            $display("FAIL reset_counters: cyc=%0d ret=%0d want 0/0", io_cycle_cnt, io_instret);
        end
    endtask

    task automatic test_alu();
        push(3'd0, 1'b0); push(3'd1, 1'b0); push(3'd2, 1'b0); push(3'd5, 1'b1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if ({io_state, io_rf_wen, io_imem_req_valid, io_dmem_req_valid} !== e) begin
                errors++;
                $display("FAIL alu_seq: got st=%0d rf=%b iv=%b dv=%b want st=%0d rf=%b iv=%b dv=%b",
                         io_state, io_rf_wen, io_imem_req_valid, io_dmem_req_valid, e.st, e.rf, e.iv, e.dv);
            end
            step();
        end
        checks++;
        if ({io_state, io_pc, io_instret, io_cycle_cnt} !== {3'd0, RPC + 64'd4, 64'd1, 64'd4}) begin
            errors++;
            $display("FAIL alu_retire: st=%0d pc=%h ret=%0d cyc=%0d want st=0 pc=%h ret=1 cyc=4",
                     io_state, io_pc, io_instret, io_cycle_cnt, RPC + 64'd4);
        end
    endtask

    task automatic test_back_to_back_store();
        imem_word = I_SD; dmem_delay = 3;
        push(3'd0, 1'b0); push(3'd1, 1'b0); push(3'd2, 1'b0);
        for (int i = 0; i < 4; i++) push(3'd3, 1'b0);
        push(3'd4, 1'b0); push(3'd5, 1'b0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if ({io_state, io_rf_wen, io_imem_req_valid, io_dmem_req_valid} !== e) begin
                errors++;
                $display("FAIL store_seq: got st=%0d rf=%b iv=%b dv=%b want st=%0d rf=%b iv=%b dv=%b",
                         io_state, io_rf_wen, io_imem_req_valid, io_dmem_req_valid, e.st, e.rf, e.iv, e.dv);
            end
            step();
        end
        checks++;
        if ({io_state, io_pc, io_instret, io_cycle_cnt} !== {3'd0, RPC + 64'd8, 64'd2, 64'd13}) begin
            errors++;
            $display("FAIL store_retire: st=%0d pc=%h ret=%0d cyc=%0d want st=0 pc=%h ret=2 cyc=13",
                     io_state, io_pc, io_instret, io_cycle_cnt, RPC + 64'd8);
        end
        dmem_delay = 0;
    endtask

    task automatic test_ebreak();
        imem_word = I_EBRK;
        apply_reset();
        push(3'd0, 1'b0); push(3'd1, 1'b0); push(3'd2, 1'b0); push(3'd6, 1'b0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if ({io_state, io_rf_wen, io_imem_req_valid, io_dmem_req_valid} !== e) begin
                errors++;
                $display("FAIL ebreak_seq: got st=%0d rf=%b iv=%b dv=%b want st=%0d rf=%b iv=%b dv=%b",
                         io_state, io_rf_wen, io_imem_req_valid, io_dmem_req_valid, e.st, e.rf, e.iv, e.dv);
            end
            step();
        end
        checks++;
        if ({io_halt, io_halt_code, io_instret, io_cycle_cnt} !== {1'b1, 2'd1, 64'd1, 64'd3}) begin
            errors++;
            $display("FAIL ebreak_halt: halt=%b code=%0d ret=%0d cyc=%0d want 1/1/1/3",
                     io_halt, io_halt_code, io_instret, io_cycle_cnt);
        end
        for (int i = 0; i < 5; i++) step();
        checks++;
        if ({io_state, io_imem_req_valid, io_cycle_cnt, io_instret, io_pc} !== {3'd6, 1'b0, 64'd3, 64'd1, RPC}) begin
            errors++;
            $display("FAIL ebreak_frozen: st=%0d iv=%b cyc=%0d ret=%0d pc=%h want 6/0/3/1/%h",
                     io_state, io_imem_req_valid, io_cycle_cnt, io_instret, io_pc, RPC);
        end
    endtask

    task automatic test_illegal();
        imem_word = I_ILL;
        apply_reset();
        push(3'd0, 1'b0); push(3'd1, 1'b0); push(3'd2, 1'b0); push(3'd6, 1'b0); push(3'd6, 1'b0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if ({io_state, io_rf_wen, io_imem_req_valid, io_dmem_req_valid} !== e) begin
                errors++;
                $display("FAIL illegal_seq: got st=%0d rf=%b iv=%b dv=%b want st=%0d rf=%b iv=%b dv=%b",
                         io_state, io_rf_wen, io_imem_req_valid, io_dmem_req_valid, e.st, e.rf, e.iv, e.dv);
            end
            step();
        end
        checks++;
        if ({io_halt, io_halt_code, io_instret} !== {1'b1, 2'd2, 64'd0}) begin
            errors++;
            $display("FAIL illegal_halt: halt=%b code=%0d ret=%0d want 1/2/0", io_halt, io_halt_code, io_instret);
        end
    endtask

    task automatic test_timeout();
        imem_word = I_ADDI; imem_delay = 1_000_000;
        apply_reset();
        for (int i = 0; i < TIMEOUT; i++) push(3'd0, 1'b0);
        push(3'd6, 1'b0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if ({io_state, io_rf_wen, io_imem_req_valid, io_dmem_req_valid} !== e) begin
                errors++;
                $display("FAIL timeout_seq: got st=%0d rf=%b iv=%b dv=%b want st=%0d rf=%b iv=%b dv=%b",
                         io_state, io_rf_wen, io_imem_req_valid, io_dmem_req_valid, e.st, e.rf, e.iv, e.dv);
            end
            step();
        end
        checks++;
        if ({io_halt, io_halt_code, io_cycle_cnt} !== {1'b1, 2'd3, 64'(TIMEOUT)}) begin
            errors++;
            $display("FAIL timeout_halt: halt=%b code=%0d cyc=%0d want 1/3/%0d", io_halt, io_halt_code, io_cycle_cnt, TIMEOUT);
        end
        // Ready arrives in the last allowed cycle: exit beats timeout.
        imem_delay = TIMEOUT - 1;
        apply_reset();
        for (int i = 0; i < TIMEOUT; i++) push(3'd0, 1'b0);
        push(3'd1, 1'b0); push(3'd2, 1'b0); push(3'd5, 1'b1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if ({io_state, io_rf_wen, io_imem_req_valid, io_dmem_req_valid} !== e) begin
                errors++;
                $display("FAIL edge_ready_seq: got st=%0d rf=%b iv=%b dv=%b want st=%0d rf=%b iv=%b dv=%b",
                         io_state, io_rf_wen, io_imem_req_valid, io_dmem_req_valid, e.st, e.rf, e.iv, e.dv);
            end
            step();
        end
        checks++;
        if ({io_halt, io_halt_code, io_instret, io_pc} !== {1'b0, 2'd0, 64'd1, RPC + 64'd4}) begin
            errors++;
            $display("FAIL edge_ready_end: halt=%b code=%0d ret=%0d pc=%h want 0/0/1/%h",
                     io_halt, io_halt_code, io_instret, io_pc, RPC + 64'd4);
        end
        imem_delay = 0;
    endtask

    task automatic test_reset_mid_mresp();
        imem_word = I_LD; imem_delay = 0; dmem_delay = 0; dmem_resp_en = 1'b0;
        apply_reset();
        push(3'd0, 1'b0); push(3'd1, 1'b0); push(3'd2, 1'b0); push(3'd3, 1'b0); push(3'd4, 1'b0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if ({io_state, io_rf_wen, io_imem_req_valid, io_dmem_req_valid} !== e) begin
                errors++;
                $display("FAIL mresp_seq: got st=%0d rf=%b iv=%b dv=%b want st=%0d rf=%b iv=%b dv=%b",
                         io_state, io_rf_wen, io_imem_req_valid, io_dmem_req_valid, e.st, e.rf, e.iv, e.dv);
            end
            if (sb.size() != 0) step();
        end
        // Still in MRESP here; pulse reset for a single edge.
        apply_reset();
        checks++;
        if ({io_state, io_pc, io_cycle_cnt, io_instret, io_inst} !== {3'd0, RPC, 64'd0, 64'd0, 32'd0}) begin
            errors++;
            $display("FAIL mid_reset: st=%0d pc=%h cyc=%0d ret=%0d inst=%h want 0/%h/0/0/0",
                     io_state, io_pc, io_cycle_cnt, io_instret, io_inst, RPC);
        end
        // Late responses from the abandoned transaction while fetching.
        stale_en = 1'b1; imem_delay = 2;
        drive();
        push(3'd0, 1'b0); push(3'd0, 1'b0); push(3'd0, 1'b0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if ({io_state, io_rf_wen, io_imem_req_valid, io_dmem_req_valid} !== e) begin
                errors++;
                $display("FAIL stale_seq: got st=%0d rf=%b iv=%b dv=%b want st=%0d rf=%b iv=%b dv=%b",
                         io_state, io_rf_wen, io_imem_req_valid, io_dmem_req_valid, e.st, e.rf, e.iv, e.dv);
            end
            step();
        end
        checks++;
        if ({io_state, io_inst} !== {3'd1, 32'd0}) begin
            errors++;
            $display("FAIL stale_ignored: st=%0d inst=%h want 1/00000000", io_state, io_inst);
        end
        stale_en = 1'b0; dmem_resp_en = 1'b1; imem_delay = 0;
        drive();
        push(3'd1, 1'b0); push(3'd2, 1'b0); push(3'd3, 1'b0); push(3'd4, 1'b0); push(3'd5, 1'b1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if ({io_state, io_rf_wen, io_imem_req_valid, io_dmem_req_valid} !== e) begin
                errors++;
                $display("FAIL load_seq: got st=%0d rf=%b iv=%b dv=%b want st=%0d rf=%b iv=%b dv=%b",
                         io_state, io_rf_wen, io_imem_req_valid, io_dmem_req_valid, e.st, e.rf, e.iv, e.dv);
            end
            step();
        end
        checks++;
        if ({io_state, io_instret, io_pc, io_inst} !== {3'd0, 64'd1, RPC + 64'd4, I_LD}) begin
            errors++;
            $display("FAIL load_retire: st=%0d ret=%0d pc=%h inst=%h want 0/1/%h/%h",
                     io_state, io_instret, io_pc, io_inst, RPC + 64'd4, I_LD);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back_store();
        test_ebreak();
        test_illegal();
        test_timeout();
        test_reset_mid_mresp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
